// File: rtl/io_bus_bridge_if.sv
// io_bus_bridge_if: MCS I/O bus plus per-bank peripheral signals.
// "master" is the MCS/peripheral side, "slave" is the bridge itself.
interface io_bus_bridge_if #(
  parameter int NBANK = 8
);
  logic [31:0]         io_address;
  logic                io_addr_strobe;
  logic                io_read_strobe;
  logic                io_write_strobe;
  logic [31:0]         io_read_data;
  logic                io_ready;
  logic [NBANK-1:0]    wr;
  logic [NBANK*32-1:0] rdata;
  logic [NBANK-1:0]    bankrdy;
  logic                busy;
  logic                timeout_err;

  modport master (
    output io_address, io_addr_strobe, io_read_strobe, io_write_strobe,
    output rdata, bankrdy,
    input  io_read_data, io_ready, wr, busy, timeout_err
  );

  modport slave (
    input  io_address, io_addr_strobe, io_read_strobe, io_write_strobe,
    input  rdata, bankrdy,
    output io_read_data, io_ready, wr, busy, timeout_err
  );
endinterface

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: decodes the MCS I/O bus into NBANK peripheral banks,
// issues a registered one-hot write strobe, muxes bank read data back and
// generates io_ready. Slow banks (SLOW_MASK) complete on their bankrdy bit.
// Optional watchdog on slow banks: define IO_BUS_BRIDGE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for io_addr_strobe
// FAST  | fixed-latency or null access, capture data next edge
// WAIT  | slow bank, waiting for its bankrdy (or the watchdog)
// DONE  | io_ready pulse, back to IDLE
module io_bus_bridge #(
  parameter int          NBANK     = 8,
  parameter int          BSEL_LSB  = 28,
  parameter logic [15:0] SLOW_MASK = 16'h0003,
  parameter int          TIMEOUT   = 1023,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_DEAD
) (
  input  logic          clk,
  input  logic          rst,
  io_bus_bridge_if.slave bus
);

  localparam int BW = $clog2(NBANK);

  typedef enum logic [1:0] {IDLE, FAST, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    bank_sel, bank;
  logic             in_range, slow_sel, is_write, accept;
  logic             null_acc, capture, timed_out, bankrdy_sel;
  logic [NBANK-1:0] wr_onehot, wr_q;
  logic [31:0]      rdata_sel, read_data_q;

  assign bank_sel = bus.io_address[BSEL_LSB +: BW];
  assign in_range = (32'(bank_sel) < 32'(NBANK));
  assign slow_sel = SLOW_MASK[bank_sel];
  // Neither or both qualifiers count as a read.
  assign is_write = bus.io_write_strobe & ~bus.io_read_strobe;
  assign accept   = (state == IDLE) & bus.io_addr_strobe;

  // Decode the incoming bank and select the latched bank's data/ready.
  always_comb begin
    wr_onehot   = '0;
    rdata_sel   = '0;
    bankrdy_sel = 1'b0;
    for (int i = 0; i < NBANK; i++) begin
      wr_onehot[i] = (bank_sel == BW'(i));
      if (bank == BW'(i)) begin
        rdata_sel   = bus.rdata[32*i +: 32];
        bankrdy_sel = bus.bankrdy[i];
      end
    end
  end

`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_err_q;

  // bankrdy wins over a coincident timeout.
  assign timed_out = (state == WAIT) && !bankrdy_sel && (wait_cnt == 16'(TIMEOUT));

  // Saturating wait counter (zero outside WAIT) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state != WAIT)
        wait_cnt <= '0;
      else if (wait_cnt != 16'hFFFF)
        wait_cnt <= wait_cnt + 16'd1;
      if (timed_out)
        timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  logic unused_cfg;

  assign timed_out       = 1'b0;
  assign bus.timeout_err = 1'b0;
  assign unused_cfg      = ^32'(TIMEOUT);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and data capture control.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (bus.io_addr_strobe) state_nxt = (in_range && slow_sel) ? WAIT : FAST;
      FAST: begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      WAIT: begin
        if (bankrdy_sel) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (timed_out) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the access, pulse wr for one cycle, capture read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank        <= '0;
      null_acc    <= 1'b0;
      wr_q        <= '0;
      read_data_q <= '0;
    end else begin
      wr_q <= (accept && in_range && is_write) ? wr_onehot : '0;
      if (accept) begin
        bank     <= bank_sel;
        null_acc <= !in_range;
      end
      if (capture)
        read_data_q <= null_acc ? 32'h0 : rdata_sel;
      else if (timed_out)
        read_data_q <= ERR_DATA;
    end
  end

  assign bus.wr           = wr_q;
  assign bus.io_read_data = read_data_q;
  assign bus.io_ready     = (state == DONE);
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_io_bus_bridge.sv
// tb_io_bus_bridge: directed bench with a read-data scoreboard for
// io_bus_bridge (NBANK=8) plus a second instance with NBANK=6 for
// out-of-range decoding.
module tb_io_bus_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  int ready_cnt = 0;
  int snap;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  io_bus_bridge_if #(.NBANK(8)) bus ();
  io_bus_bridge_if #(.NBANK(6)) bus6 ();

  io_bus_bridge #(.NBANK(8), .BSEL_LSB(28), .SLOW_MASK(16'h0003),
                  .TIMEOUT(16), .ERR_DATA(32'hDEAD_DEAD))
    dut (.clk(clk), .rst(rst), .bus(bus));

  io_bus_bridge #(.NBANK(6), .BSEL_LSB(28), .SLOW_MASK(16'h0003),
                  .TIMEOUT(16), .ERR_DATA(32'hDEAD_DEAD))
    dut6 (.clk(clk), .rst(rst), .bus(bus6));

  always @(posedge clk) if (bus.io_ready === 1'b1) ready_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] addr, input logic rd, input logic wq,
                       input bit expect_done, input logic [31:0] exp_data);
    bus.io_address      = addr;
    bus.io_addr_strobe  = 1'b1;
    bus.io_read_strobe  = rd;
    bus.io_write_strobe = wq;
    if (expect_done) exp_q.push_back(exp_data);
    tick;
    bus.io_addr_strobe  = 1'b0;
    bus.io_read_strobe  = 1'b0;
    bus.io_write_strobe = 1'b0;
  endtask

  // n0 = edges elapsed since (and including) the accepting edge.
  task automatic finish_access(input string tag, input int exp_lat, input int n0, input int budget);
    int n;
    logic [31:0] exp;
    n = n0;
    while (bus.io_ready !== 1'b1 && n < budget) begin
      tick;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " wr clear"}, 32'(bus.wr), 32'h0);
    check({tag, " scoreboard"}, 32'(exp_q.size() != 0), 32'h1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, " data"}, bus.io_read_data, exp);
    end
    tick;
    check({tag, " ready pulse"}, 32'(bus.io_ready), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.bankrdy = '0;
    bus6.bankrdy = '0;
    for (int i = 0; i < 8; i++) bus.rdata[32*i +: 32] = 32'hA000_0000 | 32'(i);
    for (int i = 0; i < 6; i++) bus6.rdata[32*i +: 32] = 32'hA000_0000 | 32'(i);
    bus.rdata[64 +: 32]  = 32'h1234_5678;
    bus6.rdata[64 +: 32] = 32'h1234_5678;

    // Reset held low for 3 cycles with strobes active.
    bus.io_address = 32'h2000_0000; bus.io_addr_strobe = 1'b1;
    bus.io_read_strobe = 1'b0; bus.io_write_strobe = 1'b1;
    bus6.io_address = 32'h2000_0000; bus6.io_addr_strobe = 1'b1;
    bus6.io_read_strobe = 1'b0; bus6.io_write_strobe = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      check("rst wr", 32'(bus.wr), 32'h0);
      check("rst ready", 32'(bus.io_ready), 32'h0);
    end
    check("rst busy", 32'(bus.busy), 32'h0);
    check("rst data", bus.io_read_data, 32'h0);
    check("rst timeout_err", 32'(bus.timeout_err), 32'h0);
    check("rst busy6", 32'(bus6.busy), 32'h0);
    check("rst ready count", 32'(ready_cnt), 32'h0);
    bus.io_addr_strobe = 1'b0; bus.io_write_strobe = 1'b0;
    bus6.io_addr_strobe = 1'b0; bus6.io_write_strobe = 1'b0;
    rst = 1'b1;
    tick;

    // Fast write to bank 2 (write also captures bank data).
    bus.rdata[64 +: 32] = 32'h5555_AAAA;
    start(32'h2000_0000, 1'b0, 1'b1, 1'b1, 32'h5555_AAAA);
    check("fast wr strobe", 32'(bus.wr), 32'h04);
    check("fast wr busy", 32'(bus.busy), 32'h1);
    check("fast wr ready early", 32'(bus.io_ready), 32'h0);
    finish_access("fast wr", 2, 1, 10);

    // Fast read of bank 2.
    bus.rdata[64 +: 32] = 32'h1234_5678;
    start(32'h2000_0000, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    check("fast rd wr", 32'(bus.wr), 32'h0);
    finish_access("fast rd", 2, 1, 10);

    // Neither qualifier and both qualifiers behave as reads.
    start(32'h5000_0000, 1'b0, 1'b0, 1'b1, 32'hA000_0005);
    check("noqual wr", 32'(bus.wr), 32'h0);
    finish_access("noqual", 2, 1, 10);
    start(32'h7000_0000, 1'b1, 1'b1, 1'b1, 32'hA000_0007);
    check("bothqual wr", 32'(bus.wr), 32'h0);
    finish_access("bothqual", 2, 1, 10);

    // Write to bank 6.
    start(32'h6000_0000, 1'b0, 1'b1, 1'b1, 32'hA000_0006);
    check("wr bank6 strobe", 32'(bus.wr), 32'h40);
    finish_access("wr bank6", 2, 1, 10);

    // Slow bank 0 already ready: same latency as a fast bank.
    bus.bankrdy[0] = 1'b1;
    start(32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'hA000_0000);
    finish_access("slow imm", 2, 1, 10);
    bus.bankrdy[0] = 1'b0;

    // Slow read of bank 0, ready sampled 5 edges after the strobe;
    // bank 1's ready toggles meanwhile and must be ignored.
    bus.rdata[0 +: 32] = 32'hC0DE_0000;
    snap = ready_cnt;
    start(32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'hC0DE_0000);
    for (int k = 1; k <= 4; k++) begin
      check("slow wait busy", 32'(bus.busy), 32'h1);
      check("slow wait ready", 32'(bus.io_ready), 32'h0);
      bus.bankrdy[1] = ~bus.bankrdy[1];
      tick;
    end
    bus.bankrdy[0] = 1'b1;
    finish_access("slow", 6, 5, 10);
    bus.bankrdy = '0;
    check("slow ready once", 32'(ready_cnt - snap), 32'h1);

`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
    // bankrdy arriving in the timeout cycle wins.
    start(32'h1000_0000, 1'b1, 1'b0, 1'b1, 32'hA000_0001);
    repeat (16) tick;
    bus.bankrdy[1] = 1'b1;
    finish_access("tmo tie", 18, 17, 30);
    bus.bankrdy[1] = 1'b0;
    check("tmo tie err", 32'(bus.timeout_err), 32'h0);
    // Real timeout on bank 1.
    start(32'h1000_0000, 1'b1, 1'b0, 1'b1, 32'hDEAD_DEAD);
    finish_access("tmo", 18, 1, 40);
    check("tmo err set", 32'(bus.timeout_err), 32'h1);
    tick;
    check("tmo err sticky", 32'(bus.timeout_err), 32'h1);
`else
    // Without the watchdog a slow bank waits indefinitely.
    snap = ready_cnt;
    start(32'h1000_0000, 1'b1, 1'b0, 1'b1, 32'hA000_0001);
    repeat (30) tick;
    check("long wait busy", 32'(bus.busy), 32'h1);
    check("long wait no ready", 32'(ready_cnt - snap), 32'h0);
    check("long wait err", 32'(bus.timeout_err), 32'h0);
    bus.bankrdy[1] = 1'b1;
    finish_access("long wait", 32, 31, 40);
    bus.bankrdy[1] = 1'b0;
`endif

    // Strobe during WAIT is ignored; reset mid-WAIT aborts silently.
    snap = ready_cnt;
    start(32'h1000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    tick;
    bus.io_address = 32'h2000_0000;
    bus.io_addr_strobe = 1'b1; bus.io_write_strobe = 1'b1;
    tick;
    bus.io_addr_strobe = 1'b0; bus.io_write_strobe = 1'b0;
    check("wait strobe wr", 32'(bus.wr), 32'h0);
    check("wait strobe busy", 32'(bus.busy), 32'h1);
    rst = 1'b0;
    tick;
    check("abort busy", 32'(bus.busy), 32'h0);
    check("abort ready", 32'(bus.io_ready), 32'h0);
    rst = 1'b1;
    tick;
    tick;
    check("abort no ready", 32'(ready_cnt - snap), 32'h0);
    start(32'h4000_0000, 1'b1, 1'b0, 1'b1, 32'hA000_0004);
    finish_access("after abort", 2, 1, 10);

    // NBANK=6: bank 2 read, then out-of-range write to bank 7.
    bus6.io_address = 32'h2000_0000;
    bus6.io_addr_strobe = 1'b1; bus6.io_read_strobe = 1'b1;
    tick;
    bus6.io_addr_strobe = 1'b0; bus6.io_read_strobe = 1'b0;
    tick;
    check("nb6 rd ready", 32'(bus6.io_ready), 32'h1);
    check("nb6 rd data", bus6.io_read_data, 32'h1234_5678);
    tick;
    bus6.io_address = 32'h7000_0000;
    bus6.io_addr_strobe = 1'b1; bus6.io_write_strobe = 1'b1;
    tick;
    bus6.io_addr_strobe = 1'b0; bus6.io_write_strobe = 1'b0;
    check("oor wr", 32'(bus6.wr), 32'h0);
    check("oor busy", 32'(bus6.busy), 32'h1);
    tick;
    check("oor ready", 32'(bus6.io_ready), 32'h1);
    check("oor data", bus6.io_read_data, 32'h0);
    check("oor wr late", 32'(bus6.wr), 32'h0);
    tick;
    check("oor idle", 32'(bus6.busy), 32'h0);

    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
